score_counter: RTL and testbench

Game score keeper that sits directly upstream of the seven-segment scan logic in the top level. It counts gameplay progress in packed BCD, so each 4-bit SSD digit shows a decimal 0–9. It also tracks a high score and a three-state run/over status, and drives a blink flag for the game-over display. It runs in the movement-clock domain alongside the game logic.

---
 rtl/score_counter_pkg.sv | 16 +
 rtl/score_counter_bcd_inc4.sv | 41 ++++
 rtl/score_counter.sv | 122 ++++++++++++
 tb/tb_score_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/score_counter_pkg.sv
// Shared definitions for the game score keeper: status encodings and BCD limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package score_counter_pkg;

  // Run/over status as shown to the top level; 2'b11 is never entered.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  // Largest score representable in four packed BCD digits.
  localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/score_counter_bcd_inc4.sv
// Combinational 4-digit packed-BCD +1 with saturation at 9999.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever val is.
// Ports:
//   val      in  16  current value, 4 packed BCD digits ([15:12] = thousands)
//   inc_val  out 16  val + 1 in BCD, or val unchanged when already at 9999
//   sat      out  1  val is at the saturation point (9999)
module bcd_inc4
  import score_counter_pkg::*;
(
  input  logic [15:0] val,
  output logic [15:0] inc_val,
  output logic        sat
);

  logic carry;

  always_comb begin
    inc_val = val;
    carry   = 1'b1;
    sat     = (val == BCD_MAX);
    // Ripple the +1 up the digits: a 9 becomes 0 and passes the carry on,
    // anything else absorbs it.
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (val[i*4 +: 4] == 4'd9) begin
          inc_val[i*4 +: 4] = 4'd0;
          carry             = 1'b1;
        end else begin
          inc_val[i*4 +: 4] = val[i*4 +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    // Without this the chain would wrap 9999 to 0000.
    if (sat) begin
      inc_val = val;
    end
  end

endmodule

// File: rtl/score_counter.sv
// Game score keeper: BCD score, high score, IDLE/RUN/OVER status and game-over blink.
// Latency: 1 cycle from any input pulse to the registered outputs.
// Backpressure: none; every active input cycle is consumed as one event.
// Ports:
//   clk       in   1  movement clock
//   rst       in   1  synchronous active-high reset, clears everything incl. high score
//   start     in   1  begin a run (from IDLE or OVER)
//   tick      in   1  one per game frame; drives the point prescaler and the blink
//   crash     in   1  end the current run
//   score     out 16  current score, packed BCD
//   hi_score  out 16  best finished-run score since reset, packed BCD
//   state     out  2  00 IDLE, 01 RUN, 10 OVER
//   blank     out  1  blink phase in OVER (1 = blank the digits)
//   new_hi    out  1  the last finished run set a new high score
module score_counter
  import score_counter_pkg::*;
#(
  parameter int TICKS_PER_POINT = 8,
  parameter int BLINK_TICKS     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        tick,
  input  logic        crash,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [1:0]  state,
  output logic        blank,
  output logic        new_hi
);

  // Counter widths stay at least 1 bit so a divide-by-1 still elaborates.
  localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICKS_PER_POINT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  state_t          st;
  logic [PW-1:0]   prescaler;
  logic [BW-1:0]   blink_cnt;
  logic [15:0]     score_inc;
  logic            score_sat;

  bcd_inc4 u_inc (
    .val     (score),
    .inc_val (score_inc),
    .sat     (score_sat)
  );

  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      score     <= '0;
      hi_score  <= '0;
      blank     <= 1'b0;
      new_hi    <= 1'b0;
      prescaler <= '0;
      blink_cnt <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          score <= '0;
          blank <= 1'b0;
          if (start) begin
            st        <= ST_RUN;
            prescaler <= '0;
          end
        end

        ST_RUN: begin
          blank <= 1'b0;
          // Crash takes priority so a point landing on the crash frame is lost.
          if (crash) begin
            st <= ST_OVER;
            if (score > hi_score) begin
              hi_score <= score;
              new_hi   <= 1'b1;
            end else begin
              new_hi <= 1'b0;
            end
          end else if (tick) begin
            if (prescaler == PRE_LAST) begin
              prescaler <= '0;
              if (!score_sat) begin
                score <= score_inc;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
        end

        ST_OVER: begin
          if (start) begin
            st        <= ST_RUN;
            score     <= '0;
            prescaler <= '0;
            blink_cnt <= '0;
            blank     <= 1'b0;
          end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blank     <= ~blank;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end

        default: begin
          // Recovery from the unused encoding.
          st    <= ST_IDLE;
          blank <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: default-parameter instance for the game flow,
// plus a divide-by-1 instance to reach the BCD carry and saturation corners quickly.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_score_counter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        tick;
  logic        crash;

  logic [15:0] score, hi_score;
  logic [1:0]  state;
  logic        blank, new_hi;

  logic [15:0] f_score, f_hi_score;
  logic [1:0]  f_state;
  logic        f_blank, f_new_hi;

  int n_cmp;
  int n_bad;

  score_counter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tick     (tick),
    .crash    (crash),
    .score    (score),
    .hi_score (hi_score),
    .state    (state),
    .blank    (blank),
    .new_hi   (new_hi)
  );

  score_counter #(.TICKS_PER_POINT(1), .BLINK_TICKS(32)) dut_fast (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tick     (tick),
    .crash    (crash),
    .score    (f_score),
    .hi_score (f_hi_score),
    .state    (f_state),
    .blank    (f_blank),
    .new_hi   (f_new_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock with the given pulses applied, then all pulses dropped.
  task automatic step(input logic r, input logic s, input logic t, input logic c);
    rst = r; start = s; tick = t; crash = c;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; tick = 1'b0; crash = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; start = 1'b0; tick = 1'b0; crash = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state
    check_eq("rst_score",  score,          16'h0000);
    check_eq("rst_hi",     hi_score,       16'h0000);
    check_eq("rst_state",  {14'd0, state}, 16'h0000);
    check_eq("rst_blank",  {15'd0, blank}, 16'h0000);
    check_eq("rst_new_hi", {15'd0, new_hi},16'h0000);

    // IDLE ignores ticks and crash
    ticks(20);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("idle_score", score,          16'h0000);
    check_eq("idle_state", {14'd0, state}, 16'h0000);
    check_eq("idle_blank", {15'd0, blank}, 16'h0000);

    // Start and count points
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("start_state", {14'd0, state}, 16'h0001);
    ticks(24);
    check_eq("run_3pts",  score, 16'h0003);
    ticks(7);
    check_eq("run_7more", score, 16'h0003);
    ticks(1);
    check_eq("run_4pts",  score, 16'h0004);
    ticks(64);
    check_eq("run_12pts", score, 16'h0012);

    // Crash together with the point-completing tick
    ticks(7);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("crash_score",  score,           16'h0012);
    check_eq("crash_state",  {14'd0, state},  16'h0002);
    check_eq("crash_hi",     hi_score,        16'h0012);
    check_eq("crash_new_hi", {15'd0, new_hi}, 16'h0001);

    // Blink in OVER; crash ignored there
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("over_crash_state", {14'd0, state}, 16'h0002);
    ticks(31);
    check_eq("blink_31", {15'd0, blank}, 16'h0000);
    ticks(1);
    check_eq("blink_32", {15'd0, blank}, 16'h0001);
    ticks(32);
    check_eq("blink_64", {15'd0, blank}, 16'h0000);
    ticks(32);
    check_eq("blink_96", {15'd0, blank}, 16'h0001);
    check_eq("over_frozen", score, 16'h0012);

    // Restart from OVER
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("restart_state",  {14'd0, state},  16'h0001);
    check_eq("restart_score",  score,           16'h0000);
    check_eq("restart_blank",  {15'd0, blank},  16'h0000);
    check_eq("restart_new_hi", {15'd0, new_hi}, 16'h0001);

    // Start mid-run must not clear the prescaler
    ticks(36);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("run_start_ign", score, 16'h0004);
    ticks(4);
    check_eq("run2_5pts", score, 16'h0005);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("crash2_state",  {14'd0, state},  16'h0002);
    check_eq("crash2_score",  score,           16'h0005);
    check_eq("crash2_hi",     hi_score,        16'h0012);
    check_eq("crash2_new_hi", {15'd0, new_hi}, 16'h0000);

    // Reset mid-run at 0042, with a tick in the same cycle
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(336);
    check_eq("run3_42", score, 16'h0042);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("midrst_score", score,          16'h0000);
    check_eq("midrst_hi",    hi_score,       16'h0000);
    check_eq("midrst_state", {14'd0, state}, 16'h0000);
    check_eq("midrst_blank", {15'd0, blank}, 16'h0000);
    check_eq("midrst_newhi", {15'd0, new_hi},16'h0000);

    // BCD carry and saturation corners on the divide-by-1 instance
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(99);
    check_eq("f_0099", f_score, 16'h0099);
    ticks(1);
    check_eq("f_0100", f_score, 16'h0100);
    ticks(899);
    check_eq("f_0999", f_score, 16'h0999);
    ticks(1);
    check_eq("f_1000", f_score, 16'h1000);
    ticks(8999);
    check_eq("f_9999", f_score, 16'h9999);
    ticks(1);
    check_eq("f_sat1", f_score, 16'h9999);
    ticks(5);
    check_eq("f_sat5", f_score, 16'h9999);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("f_hi",     f_hi_score,        16'h9999);
    check_eq("f_new_hi", {15'd0, f_new_hi}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
